// File: rtl/xspi_8s_if.sv
// Host request/response and octal IO bus of the 8S-8S-8S xSPI master.
// The master modport is the controller's view; the slave modport is the host plus flash side.
interface xspi_8s_if;
  logic        start;
  logic [7:0]  command;
  logic [47:0] address;
  logic [63:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [63:0] rd_data;
  logic        cs_n;
  logic        sck;
  logic [7:0]  io_out;
  logic        io_oe;
  logic [7:0]  io_in;

  modport master (
    input  start, command, address, wr_data, io_in,
    output busy, done, err, rd_data, cs_n, sck, io_out, io_oe
  );

  modport slave (
    output start, command, address, wr_data, io_in,
    input  busy, done, err, rd_data, cs_n, sck, io_out, io_oe
  );
endinterface

// File: rtl/xspi_8s_master.sv
// Octal-SDR xSPI master: command, 6 address bytes, then 8 write bytes or dummy + 8 read bytes.
// One SCK period is two clk cycles; a byte changes on the edge that drives sck low.
module xspi_8s_master #(
  parameter int unsigned DUMMY_CYCLES   = 4,
  parameter int unsigned CS_HIGH_CYCLES = 2
) (
  input logic        clk,
  input logic        rst_n,
  xspi_8s_if.master  bus
);

  typedef enum logic [2:0] {
    StIdle, StCmd, StAddr, StDummy, StWdata, StRdata, StCsHigh, StDone
  } state_e;

  localparam logic [7:0] CmdWrite  = 8'hA5;
  localparam logic [7:0] CmdRead   = 8'hFF;
  localparam logic [3:0] DummyLast = 4'(DUMMY_CYCLES - 1);
  localparam logic [3:0] CsLast    = 4'(CS_HIGH_CYCLES - 1);

  state_e      state_q, state_d;
  logic        ph_q, ph_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        cs_n_q, cs_n_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [47:0] addr_q, addr_d;
  logic [63:0] wdat_q, wdat_d;
  logic [63:0] rx_q, rx_d;
  logic [63:0] rd_q, rd_d;

  logic is_read, is_write;
  assign is_read  = (cmd_q == CmdRead);
  assign is_write = (cmd_q == CmdWrite);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ph_q    <= 1'b0;
      cnt_q   <= '0;
      cs_n_q  <= 1'b1;
      cmd_q   <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      rx_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      cs_n_q  <= cs_n_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rx_q    <= rx_d;
      rd_q    <= rd_d;
    end
  end

  // ph_q is the SCK level itself; it is forced low outside the active states so sck stays clean.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    cs_n_d  = cs_n_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rx_d    = rx_q;
    rd_d    = rd_q;
    unique case (state_q)
      StIdle: begin
        ph_d = 1'b0;
        if (bus.start) begin
          cmd_d   = bus.command;
          addr_d  = bus.address;
          wdat_d  = bus.wr_data;
          cnt_d   = '0;
          cs_n_d  = 1'b0;
          state_d = StCmd;
        end
      end
      StCmd: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          cnt_d   = '0;
          state_d = StAddr;
        end
      end
      StAddr: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          addr_d = addr_q << 8;
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == 4'd5) begin
            cnt_d = '0;
            if (is_write) begin
              state_d = StWdata;
            end else if (is_read) begin
              state_d = StDummy;
            end else begin
              cs_n_d  = 1'b1;
              state_d = StCsHigh;
            end
          end
        end
      end
      StDummy: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == DummyLast) begin
            cnt_d   = '0;
            state_d = StRdata;
          end
        end
      end
      StWdata: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          wdat_d = wdat_q << 8;
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d   = '0;
            cs_n_d  = 1'b1;
            state_d = StCsHigh;
          end
        end
      end
      StRdata: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          rx_d  = {rx_q[55:0], bus.io_in};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d   = '0;
            cs_n_d  = 1'b1;
            state_d = StCsHigh;
          end
        end
      end
      StCsHigh: begin
        ph_d  = 1'b0;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CsLast) begin
          cnt_d   = '0;
          state_d = StDone;
          if (is_read) begin
            rd_d = rx_q;
          end
        end
      end
      StDone: begin
        ph_d    = 1'b0;
        state_d = StIdle;
      end
      default: begin
        ph_d    = 1'b0;
        cs_n_d  = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    bus.io_oe  = 1'b0;
    bus.io_out = 8'h00;
    unique case (state_q)
      StCmd: begin
        bus.io_oe  = 1'b1;
        bus.io_out = cmd_q;
      end
      StAddr: begin
        bus.io_oe  = 1'b1;
        bus.io_out = addr_q[47:40];
      end
      StWdata: begin
        bus.io_oe  = 1'b1;
        bus.io_out = wdat_q[63:56];
      end
      default: begin
        bus.io_oe  = 1'b0;
        bus.io_out = 8'h00;
      end
    endcase
    bus.busy    = (state_q != StIdle) && (state_q != StDone);
    bus.done    = (state_q == StDone);
    bus.err     = (state_q == StDone) && !is_read && !is_write;
    bus.cs_n    = cs_n_q;
    bus.sck     = ph_q;
    bus.rd_data = rd_q;
  end

endmodule

// File: tb/tb_xspi_8s_master.sv
// Directed bench: expected IO bytes are queued when a request is issued and popped per SCK high.
// A simple flash model returns C1..C8 during the read data phase.
module tb_xspi_8s_master;
  localparam int unsigned Dummy  = 4;
  localparam int unsigned CsHigh = 2;

  logic clk;
  logic rst_n;
  xspi_8s_if bus ();

  xspi_8s_master #(
    .DUMMY_CYCLES  (Dummy),
    .CS_HIGH_CYCLES(CsHigh)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int cs_cnt = 0;
  int cs_len = 0;
  int noe_hi = 0;
  int done_cnt = 0;
  int fall_cnt = 0;
  logic sck_prev = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor and flash model, evaluated mid-cycle.
  always @(negedge clk) begin
    if (bus.cs_n === 1'b0) begin
      cs_cnt++;
      if (bus.sck && bus.io_oe) begin
        if (exp_q.size() == 0) chk("io_byte_unexpected", 64'(exp_q.size()), 64'd1);
        else chk("io_byte", {56'd0, bus.io_out}, {56'd0, exp_q.pop_front()});
      end
      if (bus.sck && !bus.io_oe) begin
        noe_hi++;
        chk("io_out_released", {56'd0, bus.io_out}, 64'd0);
      end
      if (sck_prev && !bus.sck) begin
        fall_cnt++;
        if (fall_cnt >= 7 + Dummy && fall_cnt <= 14 + Dummy)
          bus.io_in = 8'(8'hC0 + fall_cnt - 6 - Dummy);
        else
          bus.io_in = 8'h00;
      end
    end else begin
      if (cs_cnt > 0) cs_len = cs_cnt;
      cs_cnt   = 0;
      fall_cnt = 0;
      chk("sck_low_when_cs_high", {63'd0, bus.sck}, 64'd0);
    end
    if (bus.done === 1'b1) done_cnt++;
    sck_prev = bus.sck;
  end

  task automatic run_txn(input string tag, input logic [7:0] c, input logic [47:0] a,
                         input logic [63:0] w, input int exp_len, input int exp_noe,
                         input logic exp_err, input logic [63:0] exp_rd, input int inject_at);
    int d0;
    logic got;
    exp_q.push_back(c);
    for (int i = 5; i >= 0; i--) exp_q.push_back(a[8*i +: 8]);
    if (c == 8'hA5) for (int i = 7; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
    @(posedge clk); #1;
    cs_len      = 0;
    noe_hi      = 0;
    d0          = done_cnt;
    bus.command = c;
    bus.address = a;
    bus.wr_data = w;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.command = ~c;
    bus.address = ~a;
    bus.wr_data = ~w;
    if (inject_at > 0) begin
      repeat (inject_at) @(posedge clk);
      #1;
      bus.command = 8'hFF;
      bus.start   = 1'b1;
      @(posedge clk); #1;
      bus.start   = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, {63'd0, got}, 64'd1);
    chk({tag, "_err"}, {63'd0, bus.err}, {63'd0, exp_err});
    chk({tag, "_busy_at_done"}, {63'd0, bus.busy}, 64'd0);
    chk({tag, "_rd_data"}, bus.rd_data, exp_rd);
    @(negedge clk); #1;
    chk({tag, "_cs_low_len"}, 64'(cs_len), 64'(exp_len));
    chk({tag, "_released_highs"}, 64'(noe_hi), 64'(exp_noe));
    chk({tag, "_bytes_left"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    if (inject_at > 0) begin
      repeat (50) @(posedge clk);
      #1;
      chk({tag, "_no_queued_start"}, 64'(done_cnt - d0), 64'd1);
      chk({tag, "_idle_after"}, {63'd0, bus.cs_n}, 64'd1);
    end
  endtask

  localparam logic [47:0] Addr  = 48'h6655443322AB;
  localparam logic [63:0] WData = 64'h1122334455667788;
  localparam logic [63:0] RData = 64'hC1C2C3C4C5C6C7C8;
  localparam int ReadLen = 2 * (15 + Dummy);

  initial begin
    logic hit;
    bus.start   = 1'b0;
    bus.command = 8'h00;
    bus.address = '0;
    bus.wr_data = '0;
    bus.io_in   = 8'h00;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", {63'd0, bus.cs_n}, 64'd1);
    chk("rst_sck", {63'd0, bus.sck}, 64'd0);
    chk("rst_io_oe", {63'd0, bus.io_oe}, 64'd0);
    chk("rst_io_out", {56'd0, bus.io_out}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_err", {63'd0, bus.err}, 64'd0);
    chk("rst_rd_data", bus.rd_data, 64'd0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_cs_n", {63'd0, bus.cs_n}, 64'd1);
    chk("idle_busy", {63'd0, bus.busy}, 64'd0);
    chk("idle_no_done", 64'(done_cnt), 64'd0);

    run_txn("write", 8'hA5, Addr, WData, 30, 0, 1'b0, 64'd0, 0);
    run_txn("read", 8'hFF, Addr, 64'h0, ReadLen, Dummy + 8, 1'b0, RData, 0);
    run_txn("unsup", 8'h3C, Addr, WData, 14, 0, 1'b1, RData, 0);
    run_txn("busy_rej", 8'hA5, 48'h0102030405A6, 64'hF0E1D2C3B4A59687, 30, 0, 1'b0, RData, 10);
    run_txn("b2b_wr", 8'hA5, 48'h123456789ABC, 64'hDEADBEEFCAFEF00D, 30, 0, 1'b0, RData, 0);
    run_txn("b2b_rd", 8'hFF, 48'hFFEEDDCCBBAA, 64'h0, ReadLen, Dummy + 8, 1'b0, RData, 0);

    // Abort a read during its third data byte.
    exp_q.push_back(8'hFF);
    for (int i = 5; i >= 0; i--) exp_q.push_back(Addr[8*i +: 8]);
    @(posedge clk); #1;
    bus.command = 8'hFF;
    bus.address = Addr;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (fall_cnt == 9 + Dummy) begin
        hit = 1'b1;
        break;
      end
    end
    chk("abort_reached_byte3", {63'd0, hit}, 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_cs_n", {63'd0, bus.cs_n}, 64'd1);
    chk("abort_sck", {63'd0, bus.sck}, 64'd0);
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);
    chk("abort_io_oe", {63'd0, bus.io_oe}, 64'd0);
    chk("abort_rd_data", bus.rd_data, 64'd0);
    chk("abort_bytes_left", 64'(exp_q.size()), 64'd0);
    begin
      int d0;
      d0 = done_cnt;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    end
    run_txn("post_abort_wr", 8'hA5, Addr, WData, 30, 0, 1'b0, 64'd0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/xspi_8s_master.md
Name: xspi_8s_master

Overview:
Octal-SDR (8S-8S-8S) xSPI master controller. It consumes the transaction request (start, command, address, wr_data) produced by the stimulus/host stage. It serialises command, address and data bytes onto an 8-bit IO bus with SCK and CS#, and returns read data plus a done pulse. Supported commands are 8'hA5 (write) and 8'hFF (read).

Parameters:
DUMMY_CYCLES, 4, SCK cycles with bus released between address and read data (read only); legal range 1-15
CS_HIGH_CYCLES, 2, clk cycles cs_n is held high after a transfer before done; legal range 1-15

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request strobe; sampled only in IDLE
command  input  8  8'hA5 = write, 8'hFF = read, any other value = unsupported
address  input  48  target address, sent MSB byte first
wr_data  input  64  write payload, sent MSB byte first
busy  output  1  transaction in progress
done  output  1  one-clk pulse at end of every accepted transaction
err  output  1  one-clk pulse together with done when the command was unsupported
rd_data  output  64  last read payload; updated only at done of a read
cs_n  output  1  chip select, active low
sck  output  1  serial clock, clk/2 while active, idle low
io_out  output  8  IO bus drive value
io_oe  output  1  1 = master drives IO bus
io_in  input  8  IO bus sampled value

Behaviour:
- Reset is asynchronous and active-low: cs_n=1, sck=0, io_out=0, io_oe=0, busy=0, done=0, err=0, rd_data=0, state IDLE. Reset mid-transaction aborts immediately; no done is issued.
- States: IDLE, CMD, ADDR, DUMMY, WDATA, RDATA, CSHIGH, DONE.
- IDLE: on a clk edge T0 with start=1, latch command, address and wr_data. The next state is CMD. After T0: cs_n=0, busy=1, io_oe=1, io_out=command, sck=0.
- Each SCK cycle is 2 clk: a low phase followed by a high phase. A new byte is placed on io_out on the edge that drives sck low; it is stable through the high phase.
- CMD: 1 SCK cycle.
- ADDR: 6 SCK cycles, bytes address[47:40] down to [7:0].
- Command decode after ADDR:
  - A5 goes to WDATA: 8 SCK cycles, wr_data[63:56] down to [7:0].
  - FF goes to DUMMY: DUMMY_CYCLES SCK cycles, io_oe=0, io_out=0. Then RDATA: 8 SCK cycles, io_oe=0.
  - Any other command goes to CSHIGH with err set.
- RDATA sampling: io_in is sampled on the clk edge that ends each sck-high phase. Bytes are shifted in MSB first; the first byte sampled becomes rd_data[63:56].
- CSHIGH: entered on the edge ending the last high phase. Sets cs_n=1, sck=0, io_oe=0, io_out=0, held for CS_HIGH_CYCLES clk.
- DONE: a single cycle with done=1, busy=0, then IDLE.
  - For reads, rd_data is loaded from the shift register on the edge entering DONE.
  - err=1 in the same cycle as done if the command was unsupported.
- cs_n low duration:
  - Write: 30 clk.
  - Read: 2*(15+DUMMY_CYCLES) clk, which is 38 with the default.
  - Unsupported: 14 clk.
- start while busy or in DONE is ignored (not queued). start in the same cycle that returns to IDLE is not accepted; acceptance needs the FSM already in IDLE.
- Latched inputs are used for the whole transfer; input changes after T0 have no effect.
- rd_data holds its value across writes and unsupported commands.
- sck never glitches: it is low whenever cs_n=1, and the first and last edges seen with cs_n=0 are a rising and a falling edge respectively.

Test Plan:
- Reset then idle: rst_n low then high, start=0 for 20 clk -> cs_n=1, sck=0, io_oe=0, busy=0, done never pulses.
- Write: A5, address 48'h6655443322AB, wr_data 64'h1122334455667788 -> io_out byte sequence A5,66,55,44,33,22,AB,11,22,33,44,55,66,77,88, each stable during sck high. cs_n low 30 clk, io_oe=1 throughout. done pulses 2 clk after cs_n rises, err=0.
- Read: FF, same address; a slave model drives 8'hC1..C8 on io_in after each sck fall in RDATA. Expect cmd/addr bytes out, 4 SCK with io_oe=0 dummy, cs_n low 38 clk, done with rd_data=64'hC1C2C3C4C5C6C7C8.
- Unsupported: command 8'h3C -> only 7 bytes sent, cs_n low 14 clk, done and err pulse together, rd_data unchanged from the previous read.
- Busy rejection: a second start with FF pulsed mid-write -> the write completes unchanged and exactly one done pulse occurs. Then back-to-back start in IDLE is accepted.
- Reset mid-read: rst_n low during RDATA byte 3 -> asynchronous return: cs_n=1, sck=0, busy=0, rd_data=0, no done pulse. A subsequent write is correct.
